branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised branch prediction and resolution unit for the RV32I core. It answers a fetch-stage lookup from a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. It then resolves JAL, JALR and conditional branches in execute, compares the outcome with the prediction carried down the pipe, and raises a flush with a redirect address on mispredict. Tables and performance counters are trained on the clock edge after resolution.

## Interface
Parameters:
- NB_WORD, 32, data/address width
- NB_OPERAND, 5, register index width
- N_ENTRIES, 64, BTB/counter entries; power of two, ≥ 2
- NB_CNT, 32, performance counter width

Derived widths:
- NB_IDX = log2(N_ENTRIES)
- NB_TAG = NB_WORD − NB_IDX − 2

Ports (reset is asynchronous, active-high; single clock domain):
- i_clock, in, 1, clock; all state updates on rising edge
- i_reset, in, 1, asynchronous active-high reset
- i_bp_enable, in, 1, 0 forces predictions not-taken; training continues
- i_fetch_pc, in, NB_WORD, address of the instruction being fetched
- o_pred_taken, out, 1, fetch prediction: redirect fetch
- o_pred_target, out, NB_WORD, predicted next PC
- i_ex_valid, in, 1, execute stage holds a valid instruction
- i_ex_pc, in, NB_WORD, address of the execute-stage instruction itself (not PC+4)
- i_ex_instruction, in, NB_WORD, execute-stage instruction word
- i_ex_rs1, in, NB_WORD, rs1 operand
- i_ex_rs2, in, NB_WORD, rs2 operand
- i_ex_pred_taken, in, 1, o_pred_taken captured at fetch for this instruction
- i_ex_pred_target, in, NB_WORD, o_pred_target captured at fetch for this instruction
- o_flush, out, 1, mispredict: squash younger instructions
- o_redirect_addr, out, NB_WORD, correct next PC when o_flush = 1, else 0
- o_wr_retaddr, out, 1, write link register
- o_rd_retaddr, out, NB_OPERAND, link destination register
- o_ret_addr, out, NB_WORD, i_ex_pc + 4
- o_branch_count, out, NB_CNT, resolved control-transfer instructions
- o_mispredict_count, out, NB_CNT, mispredicts

## Operation
**Entry state and lookup.**
- Entry fields: valid, tag[NB_TAG], target[NB_WORD], is_jump, ctr[2].
- Index = pc[NB_IDX+1:2]; tag = pc[NB_WORD-1:NB_IDX+2].
- hit = valid && tag match at i_fetch_pc.
- o_pred_taken = i_bp_enable && hit && (is_jump || ctr[1]).
- o_pred_target = o_pred_taken ? entry.target : i_fetch_pc + 4.

**Resolution** (only when i_ex_valid and opcode ∈ {JAL, JALR, BRANCH}; otherwise all resolution outputs are 0 and no state changes):
- JAL: taken; target = pc + sext(J-imm).
- JALR: taken; target = (rs1 + sext(I-imm)) & ~1.
- BRANCH: taken per funct3:
  - BEQ, BNE.
  - BLT, BGE compare signed.
  - BLTU, BGEU compare unsigned.
  - Undefined funct3 is treated as not-taken and causes no training.
  - target = pc + sext(B-imm).
- next_pc = taken ? target : pc + 4.
- Mispredict = (taken ≠ i_ex_pred_taken) || (taken && target ≠ i_ex_pred_target).
- o_flush = mispredict; o_redirect_addr = next_pc when flushing.

**Link register.**
- JAL/JALR: o_wr_retaddr = (rd ≠ 0), o_rd_retaddr = rd.
- o_ret_addr = pc + 4 for any resolved control transfer.

**Training** (rising edge after a resolved control transfer, at index of i_ex_pc):
- Jump: write valid = 1, tag, target, is_jump = 1, ctr = 2'b11.
- Branch hit: ctr saturating increment if taken, decrement if not taken; target and is_jump = 0 rewritten when taken.
- Branch miss, taken: allocate with valid = 1, tag, target, is_jump = 0, ctr = 2'b10.
- Branch miss, not taken: no allocation.
- o_branch_count increments by 1; o_mispredict_count increments on mispredict. Both saturate at all-ones (no wrap).

## Timing
- Lookup and resolution are purely combinational: zero-cycle latency.
- Table and counter writes take effect at the next rising edge.
- Same-cycle lookup and update of the same index: lookup returns the old contents (no bypass). Prediction reflects the update from the following cycle on.
- Tag aliasing across different pcs evicts silently (direct-mapped).
- Reset (async, any time including mid-update): all valid = 0, all ctr = 2'b01, is_jump = 0, targets = 0, both perf counters = 0.
- During and after reset, with no table hits:
  - o_pred_taken = 0, o_pred_target = i_fetch_pc + 4.
  - Resolution outputs are 0 while i_ex_valid = 0.
- Deasserting i_reset mid-cycle must not produce a partial table write.

## Test plan
- **Reset, then cold jump.** Reset, then fetch 0x100: o_pred_taken = 0, target 0x104. JAL x1,+0x40 at 0x100 with pred 0: o_flush = 1, redirect 0x140, o_wr_retaddr = 1, rd = 1, ret 0x104. Next cycle fetch 0x100 → pred_taken = 1, target 0x140.
- **Counter saturation.** BNE at 0x200 (+0x20), rs1≠rs2, resolved taken 3 times: first miss allocates ctr 10, then 11, stays 11. Then 2 not-taken resolutions: ctr 10 (prediction still taken, mispredict flush, redirect 0x204), then 01 (fetch 0x200 predicts not-taken).
- **Signed vs unsigned.** rs1 = 0xFFFFFFFF, rs2 = 1: BLT taken, BLTU not-taken. JALR rs1 = 0x1003, imm = 0 → target 0x1002.
- **Wrong target.** Entry at 0x300 predicts 0x400; JALR resolves to 0x500: flush = 1, redirect 0x500; next lookup target 0x500.
- **Aliasing and bypass.** N_ENTRIES = 4: pcs 0x10 and 0x20 share an index. Training 0x20 evicts 0x10's entry. A lookup of 0x10 in the same cycle as the update returns the old entry.
- **Perf counters and async reset.** Preload counters to all-ones: further events hold the value. Assert i_reset asynchronously between edges: counters read 0 immediately and all predictions are not-taken.

Source files
------------

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_unit
//  Description : Direct-mapped BTB with 2-bit direction counters for fetch
//                prediction, plus execute-stage resolution of JAL, JALR and
//                conditional branches with flush/redirect, link-register
//                outputs and saturating performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
    parameter int NB_WORD    = 32,
    parameter int NB_OPERAND = 5,
    parameter int N_ENTRIES  = 64,
    parameter int NB_CNT     = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_bp_enable,
    input  logic [NB_WORD-1:0]    i_fetch_pc,
    output logic                  o_pred_taken,
    output logic [NB_WORD-1:0]    o_pred_target,
    input  logic                  i_ex_valid,
    input  logic [NB_WORD-1:0]    i_ex_pc,
    input  logic [NB_WORD-1:0]    i_ex_instruction,
    input  logic [NB_WORD-1:0]    i_ex_rs1,
    input  logic [NB_WORD-1:0]    i_ex_rs2,
    input  logic                  i_ex_pred_taken,
    input  logic [NB_WORD-1:0]    i_ex_pred_target,
    output logic                  o_flush,
    output logic [NB_WORD-1:0]    o_redirect_addr,
    output logic                  o_wr_retaddr,
    output logic [NB_OPERAND-1:0] o_rd_retaddr,
    output logic [NB_WORD-1:0]    o_ret_addr,
    output logic [NB_CNT-1:0]     o_branch_count,
    output logic [NB_CNT-1:0]     o_mispredict_count
);

    localparam int         NB_IDX    = $clog2(N_ENTRIES);
    localparam int         NB_TAG    = NB_WORD - NB_IDX - 2;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // BTB storage and performance counters
    logic                 valid_q   [N_ENTRIES];
    logic [NB_TAG-1:0]    tag_q     [N_ENTRIES];
    logic [NB_WORD-1:0]   target_q  [N_ENTRIES];
    logic                 is_jump_q [N_ENTRIES];
    logic [1:0]           ctr_q     [N_ENTRIES];
    logic [NB_CNT-1:0]    branch_cnt_q, branch_cnt_d;
    logic [NB_CNT-1:0]    mispredict_cnt_q, mispredict_cnt_d;

    // Fetch lookup: reads the table as it stands, never the pending update
    logic [NB_IDX-1:0] fetch_idx;
    logic [NB_TAG-1:0] fetch_tag;
    logic              fetch_hit;

    assign fetch_idx     = i_fetch_pc[NB_IDX+1:2];
    assign fetch_tag     = i_fetch_pc[NB_WORD-1:NB_IDX+2];
    assign fetch_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign o_pred_taken  = i_bp_enable && fetch_hit
                           && (is_jump_q[fetch_idx] || ctr_q[fetch_idx][1]);
    assign o_pred_target = o_pred_taken ? target_q[fetch_idx] : i_fetch_pc + NB_WORD'(4);

    // Execute-stage decode
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [NB_OPERAND-1:0] rd;
    logic [NB_WORD-1:0]    imm_i, imm_b, imm_j, pc_plus4;

    assign opcode   = i_ex_instruction[6:0];
    assign funct3   = i_ex_instruction[14:12];
    assign rd       = i_ex_instruction[7 +: NB_OPERAND];
    assign imm_i    = {{(NB_WORD-12){i_ex_instruction[31]}}, i_ex_instruction[31:20]};
    assign imm_b    = {{(NB_WORD-13){i_ex_instruction[31]}}, i_ex_instruction[31],
                       i_ex_instruction[7], i_ex_instruction[30:25],
                       i_ex_instruction[11:8], 1'b0};
    assign imm_j    = {{(NB_WORD-21){i_ex_instruction[31]}}, i_ex_instruction[31],
                       i_ex_instruction[19:12], i_ex_instruction[20],
                       i_ex_instruction[30:21], 1'b0};
    assign pc_plus4 = i_ex_pc + NB_WORD'(4);

    logic               is_jal, is_jalr, is_branch, is_jump, resolved;
    logic               branch_ok, taken, mispredict, train;
    logic [NB_WORD-1:0] target, next_pc;

    // Resolve the control transfer: direction, target and mispredict
    always_comb begin
        is_jal    = i_ex_valid && (opcode == OP_JAL);
        is_jalr   = i_ex_valid && (opcode == OP_JALR);
        is_branch = i_ex_valid && (opcode == OP_BRANCH);
        is_jump   = is_jal || is_jalr;
        resolved  = is_jump || is_branch;
        branch_ok = 1'b1;
        taken     = 1'b0;
        target    = i_ex_pc + imm_b;
        if (is_jal) begin
            taken  = 1'b1;
            target = i_ex_pc + imm_j;
        end else if (is_jalr) begin
            taken  = 1'b1;
            target = (i_ex_rs1 + imm_i) & ~NB_WORD'(1);
        end else if (is_branch) begin
            case (funct3)
                3'b000:  taken = (i_ex_rs1 == i_ex_rs2);
                3'b001:  taken = (i_ex_rs1 != i_ex_rs2);
                3'b100:  taken = ($signed(i_ex_rs1) <  $signed(i_ex_rs2));
                3'b101:  taken = ($signed(i_ex_rs1) >= $signed(i_ex_rs2));
                3'b110:  taken = (i_ex_rs1 <  i_ex_rs2);
                3'b111:  taken = (i_ex_rs1 >= i_ex_rs2);
                default: branch_ok = 1'b0;   // reserved encodings: not-taken, untrained
            endcase
        end
        next_pc    = taken ? target : pc_plus4;
        mispredict = (taken != i_ex_pred_taken)
                     || (taken && (target != i_ex_pred_target));
        train      = resolved && branch_ok;
    end

    assign o_flush            = resolved && mispredict;
    assign o_redirect_addr    = o_flush ? next_pc : '0;
    assign o_wr_retaddr       = is_jump && (rd != '0);
    assign o_rd_retaddr       = is_jump ? rd : '0;
    assign o_ret_addr         = resolved ? pc_plus4 : '0;
    assign o_branch_count     = branch_cnt_q;
    assign o_mispredict_count = mispredict_cnt_q;

    // Training: next contents of the entry addressed by the execute pc
    logic [NB_IDX-1:0]  ex_idx;
    logic [NB_TAG-1:0]  ex_tag;
    logic               ex_hit, table_we_d, is_jump_d;
    logic [NB_WORD-1:0] target_d;
    logic [1:0]         ctr_d, ctr_old;

    assign ex_idx  = i_ex_pc[NB_IDX+1:2];
    assign ex_tag  = i_ex_pc[NB_WORD-1:NB_IDX+2];
    assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ctr_old = ctr_q[ex_idx];

    // Entry update and saturating perf-counter next state
    always_comb begin
        table_we_d = 1'b0;
        is_jump_d  = 1'b0;
        target_d   = target;
        ctr_d      = ctr_old;
        if (train) begin
            if (is_jump) begin
                table_we_d = 1'b1;
                is_jump_d  = 1'b1;
                ctr_d      = 2'b11;
            end else if (ex_hit) begin
                table_we_d = 1'b1;
                if (taken) begin
                    ctr_d = (ctr_old == 2'b11) ? 2'b11 : ctr_old + 2'd1;
                end else begin
                    ctr_d     = (ctr_old == 2'b00) ? 2'b00 : ctr_old - 2'd1;
                    is_jump_d = is_jump_q[ex_idx];
                    target_d  = target_q[ex_idx];
                end
            end else if (taken) begin
                table_we_d = 1'b1;
                ctr_d      = 2'b10;
            end
        end
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (train && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + NB_CNT'(1);
        end
        if (train && mispredict && (mispredict_cnt_q != '1)) begin
            mispredict_cnt_d = mispredict_cnt_q + NB_CNT'(1);
        end
    end

    // Table and counter registers; reset clears every entry asynchronously
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                tag_q[i]     <= '0;
                target_q[i]  <= '0;
                is_jump_q[i] <= 1'b0;
                ctr_q[i]     <= 2'b01;
            end
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (table_we_d) begin
                valid_q[ex_idx]   <= 1'b1;
                tag_q[ex_idx]     <= ex_tag;
                target_q[ex_idx]  <= target_d;
                is_jump_q[ex_idx] <= is_jump_d;
                ctr_q[ex_idx]     <= ctr_d;
            end
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_branch_predict_unit
//  Description : Self-checking bench for branch_predict_unit (4-entry BTB,
//                4-bit counters) with vector table and expectation queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

    localparam int NB_WORD    = 32;
    localparam int NB_OPERAND = 5;
    localparam int N_ENTRIES  = 4;
    localparam int NB_CNT     = 4;
    localparam int CNT_MAX    = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        bp_en;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_instr, ex_rs1, ex_rs2;
    logic        ex_pt;
    logic [31:0] ex_ptgt;
    logic        flush;
    logic [31:0] redirect;
    logic        wr_ret;
    logic [4:0]  rd_ret;
    logic [31:0] ret_addr;
    logic [3:0]  br_cnt, mp_cnt;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .NB_WORD   (NB_WORD),
        .NB_OPERAND(NB_OPERAND),
        .N_ENTRIES (N_ENTRIES),
        .NB_CNT    (NB_CNT)
    ) dut (
        .i_clock           (clk),
        .i_reset           (rst),
        .i_bp_enable       (bp_en),
        .i_fetch_pc        (fetch_pc),
        .o_pred_taken      (pred_taken),
        .o_pred_target     (pred_target),
        .i_ex_valid        (ex_valid),
        .i_ex_pc           (ex_pc),
        .i_ex_instruction  (ex_instr),
        .i_ex_rs1          (ex_rs1),
        .i_ex_rs2          (ex_rs2),
        .i_ex_pred_taken   (ex_pt),
        .i_ex_pred_target  (ex_ptgt),
        .o_flush           (flush),
        .o_redirect_addr   (redirect),
        .o_wr_retaddr      (wr_ret),
        .o_rd_retaddr      (rd_ret),
        .o_ret_addr        (ret_addr),
        .o_branch_count    (br_cnt),
        .o_mispredict_count(mp_cnt)
    );

    typedef struct {
        logic        bp;
        logic [31:0] fpc;
        logic        v;
        logic [31:0] pc, instr, rs1, rs2;
        logic        pt;
        logic [31:0] ptgt;
        logic        e_pt;
        logic [31:0] e_tgt;
        logic        e_fl;
        logic [31:0] e_redir;
        logic        e_wr;
        logic [4:0]  e_rd;
        logic [31:0] e_ret;
        logic        cnt;
    } vec_t;

    typedef struct {
        logic        pt;
        logic [31:0] tgt;
        logic        fl;
        logic [31:0] redir;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] ret;
        logic [3:0]  bc, mc;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_bc     = 0;
    int   m_mc     = 0;

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic logic [31:0] enc_br(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic add(input logic bp, input logic [31:0] fpc, input logic v,
                       input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic pt, input logic [31:0] ptgt,
                       input logic e_pt, input logic [31:0] e_tgt,
                       input logic e_fl, input logic [31:0] e_redir,
                       input logic e_wr, input logic [4:0] e_rd,
                       input logic [31:0] e_ret, input logic cnt);
        vec_t t;
        t.bp = bp; t.fpc = fpc; t.v = v; t.pc = pc; t.instr = instr;
        t.rs1 = rs1; t.rs2 = rs2; t.pt = pt; t.ptgt = ptgt;
        t.e_pt = e_pt; t.e_tgt = e_tgt; t.e_fl = e_fl; t.e_redir = e_redir;
        t.e_wr = e_wr; t.e_rd = e_rd; t.e_ret = e_ret; t.cnt = cnt;
        vecs.push_back(t);
    endtask

    task automatic idle(input logic [31:0] fpc, input logic e_pt, input logic [31:0] e_tgt);
        add(1, fpc, 0, 0, 0, 0, 0, 0, 0, e_pt, e_tgt, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_pc = '0; ex_instr = '0; ex_rs1 = '0; ex_rs2 = '0;
        ex_pt = 1'b0; ex_ptgt = '0;
    endtask

    task automatic check_row(input int k);
        exp_t e;
        if (sbq.size() == 0) begin
            chk($sformatf("row%0d_queue_empty", k), 32'd0, 32'd1);
            return;
        end
        e = sbq.pop_front();
        chk($sformatf("row%0d_pred_taken", k), 32'(pred_taken), 32'(e.pt));
        chk($sformatf("row%0d_pred_target", k), pred_target, e.tgt);
        chk($sformatf("row%0d_flush", k), 32'(flush), 32'(e.fl));
        chk($sformatf("row%0d_redirect", k), redirect, e.redir);
        chk($sformatf("row%0d_wr_retaddr", k), 32'(wr_ret), 32'(e.wr));
        chk($sformatf("row%0d_rd_retaddr", k), 32'(rd_ret), 32'(e.rd));
        chk($sformatf("row%0d_ret_addr", k), ret_addr, e.ret);
        chk($sformatf("row%0d_branch_count", k), 32'(br_cnt), 32'(e.bc));
        chk($sformatf("row%0d_mispredict_count", k), 32'(mp_cnt), 32'(e.mc));
    endtask

    initial begin
        exp_t e;
        // ---- vector table ----
        // cold jump
        idle(32'h100, 0, 32'h104);
        add(1, 32'h100, 1, 32'h100, enc_jal(5'd1, 21'h40), 0, 0, 0, 32'h104,
            0, 32'h104, 1, 32'h140, 1, 5'd1, 32'h104, 1);
        idle(32'h100, 1, 32'h140);
        add(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0, 0, 0, 0, 0);
        // counter saturation on BNE at 0x200
        add(1, 32'h200, 1, 32'h200, enc_br(3'b001, 13'h20), 1, 2, 0, 32'h204,
            0, 32'h204, 1, 32'h220, 0, 0, 32'h204, 1);
        for (int i = 0; i < 2; i++)
            add(1, 32'h200, 1, 32'h200, enc_br(3'b001, 13'h20), 1, 2, 1, 32'h220,
                1, 32'h220, 0, 0, 0, 0, 32'h204, 1);
        for (int i = 0; i < 2; i++)
            add(1, 32'h200, 1, 32'h200, enc_br(3'b001, 13'h20), 5, 5, 1, 32'h220,
                1, 32'h220, 1, 32'h204, 0, 0, 32'h204, 1);
        idle(32'h200, 0, 32'h204);
        // signed vs unsigned, JALR lsb clear
        add(1, 32'h204, 1, 32'h400, enc_br(3'b100, 13'h10), 32'hFFFF_FFFF, 1, 0, 32'h404,
            0, 32'h208, 1, 32'h410, 0, 0, 32'h404, 1);
        add(1, 32'h404, 1, 32'h404, enc_br(3'b110, 13'h10), 32'hFFFF_FFFF, 1, 0, 32'h408,
            0, 32'h408, 0, 0, 0, 0, 32'h408, 1);
        idle(32'h404, 0, 32'h408);
        add(1, 32'h008, 1, 32'h500, enc_jalr(5'd5, 12'h0), 32'h1003, 0, 0, 32'h504,
            0, 32'h00C, 1, 32'h1002, 1, 5'd5, 32'h504, 1);
        add(1, 32'h500, 1, 32'h008, enc_br(3'b111, 13'h8), 32'hFFFF_FFFF, 1, 0, 32'h00C,
            1, 32'h1002, 1, 32'h010, 0, 0, 32'h00C, 1);
        add(1, 32'h008, 1, 32'h00C, enc_br(3'b000, 13'h1FFC), 7, 7, 1, 32'h008,
            1, 32'h010, 0, 0, 0, 0, 32'h010, 1);
        add(1, 32'h00C, 1, 32'h040, enc_br(3'b101, 13'h10), 32'hFFFF_FFFF, 1, 0, 32'h044,
            1, 32'h008, 0, 0, 0, 0, 32'h044, 1);
        add(1, 32'h040, 1, 32'h044, enc_br(3'b010, 13'h10), 3, 3, 0, 32'h048,
            0, 32'h044, 0, 0, 0, 0, 32'h048, 0);
        add(1, 32'h044, 1, 32'h050, enc_jal(5'd0, 21'h1FFFB0), 0, 0, 1, 32'h000,
            0, 32'h048, 0, 0, 0, 0, 32'h054, 1);
        idle(32'h050, 1, 32'h000);
        // wrong target
        add(1, 32'h300, 1, 32'h300, enc_jal(5'd0, 21'h100), 0, 0, 0, 32'h304,
            0, 32'h304, 1, 32'h400, 0, 0, 32'h304, 1);
        add(1, 32'h300, 1, 32'h300, enc_jalr(5'd0, 12'h0), 32'h500, 0, 1, 32'h400,
            1, 32'h400, 1, 32'h500, 0, 0, 32'h304, 1);
        idle(32'h300, 1, 32'h500);
        // aliasing and same-cycle lookup
        add(1, 32'h300, 1, 32'h010, enc_jal(5'd0, 21'h10), 0, 0, 0, 32'h014,
            1, 32'h500, 1, 32'h020, 0, 0, 32'h014, 1);
        add(1, 32'h010, 1, 32'h020, enc_jal(5'd0, 21'h20), 0, 0, 0, 32'h024,
            1, 32'h020, 1, 32'h040, 0, 0, 32'h024, 1);
        idle(32'h010, 0, 32'h014);
        idle(32'h020, 1, 32'h040);
        // drive mispredict counter into saturation
        for (int i = 0; i < 6; i++)
            add(1, 32'h604, 1, 32'h600, enc_jal(5'd0, 21'h8), 0, 0, 0, 32'h604,
                0, 32'h608, 1, 32'h608, 0, 0, 32'h604, 1);
        idle(32'h600, 1, 32'h608);

        // ---- reset ----
        rst = 1'b1; bp_en = 1'b1; fetch_pc = 32'h100; clear_ex();
        #12;
        chk("reset_pred_taken", 32'(pred_taken), 32'd0);
        chk("reset_pred_target", pred_target, 32'h104);
        chk("reset_flush", 32'(flush), 32'd0);
        chk("reset_ret_addr", ret_addr, 32'd0);
        chk("reset_branch_count", 32'(br_cnt), 32'd0);
        chk("reset_mispredict_count", 32'(mp_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---- table-driven run ----
        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk); #1;
            bp_en = vecs[k].bp; fetch_pc = vecs[k].fpc; ex_valid = vecs[k].v;
            ex_pc = vecs[k].pc; ex_instr = vecs[k].instr; ex_rs1 = vecs[k].rs1;
            ex_rs2 = vecs[k].rs2; ex_pt = vecs[k].pt; ex_ptgt = vecs[k].ptgt;
            e.pt = vecs[k].e_pt; e.tgt = vecs[k].e_tgt; e.fl = vecs[k].e_fl;
            e.redir = vecs[k].e_redir; e.wr = vecs[k].e_wr; e.rd = vecs[k].e_rd;
            e.ret = vecs[k].e_ret; e.bc = 4'(m_bc); e.mc = 4'(m_mc);
            sbq.push_back(e);
            if (vecs[k].cnt) begin
                if (m_bc < CNT_MAX) m_bc++;
                if (vecs[k].e_fl && m_mc < CNT_MAX) m_mc++;
            end
            @(negedge clk); #1;
            check_row(k);
        end
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        // ---- async reset during a pending update ----
        @(posedge clk); #1;
        bp_en = 1'b1; fetch_pc = 32'h600;
        ex_valid = 1'b1; ex_pc = 32'h604; ex_instr = enc_jal(5'd3, 21'h20);
        ex_pt = 1'b0; ex_ptgt = 32'h608;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_branch_count", 32'(br_cnt), 32'd0);
        chk("async_rst_mispredict_count", 32'(mp_cnt), 32'd0);
        chk("async_rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("async_rst_pred_target", pred_target, 32'h604);
        clear_ex();
        #1;
        chk("async_rst_flush", 32'(flush), 32'd0);
        chk("async_rst_redirect", redirect, 32'd0);
        chk("async_rst_wr_retaddr", 32'(wr_ret), 32'd0);
        @(posedge clk); #3;
        ex_valid = 1'b1; ex_pc = 32'h604; ex_instr = enc_jal(5'd3, 21'h20);
        #1;
        rst = 1'b0;
        clear_ex();
        fetch_pc = 32'h604;
        @(posedge clk); #1;
        chk("post_rst_no_partial_write", 32'(pred_taken), 32'd0);
        chk("post_rst_target", pred_target, 32'h608);
        fetch_pc = 32'h600;
        #1;
        chk("post_rst_old_entry_gone", 32'(pred_taken), 32'd0);
        chk("post_rst_branch_count", 32'(br_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
